// File: rtl/analog_probe_scheduler.sv
// Periodic V/I/P probe sweeps: toggle request, settle, capture real value, convert to fixed-point, queue in FIFO.
// Optional build macro PROBE_TIMESTAMP_EN adds m_timestamp (request-cycle stamp stored per FIFO entry).
module analog_probe_scheduler #(
  parameter int unsigned PERIOD_W      = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned FRAC_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [2:0]          chan_mask,
  input  logic                clr_overflow,
  output logic                probe_voltage_toggle,
  output logic                probe_current_toggle,
  output logic                probe_power_toggle,
  input  real                 voltage_in,
  input  real                 current_in,
  input  real                 power_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [1:0]          m_chan,
`ifdef PROBE_TIMESTAMP_EN
  output logic [31:0]         m_timestamp,
`endif
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam real SCALE = 2.0 ** FRAC_BITS;
  localparam real LIMIT = 2.0 ** (DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt, w_reload;
  logic [SET_W-1:0]    r_set, w_set_nxt;
  logic [2:0]          r_mask, w_mask_nxt, w_rem;
  logic [1:0]          r_chan, w_chan_nxt;
  logic                w_push;
  logic [2:0]          r_toggle;
  logic                r_busy;
  logic                r_overflow;

  real                 w_sel, w_scaled, w_trunc;
  logic [DATA_W-1:0]   w_conv;

  logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [1:0]          r_mem_chan [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0]    r_count;
  logic                w_pop, w_full, w_do_push, w_drop;

  function automatic logic [1:0] f_lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  assign w_reload = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_set   <= '0;
      r_mask  <= '0;
      r_chan  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_set   <= w_set_nxt;
      r_mask  <= w_mask_nxt;
      r_chan  <= w_chan_nxt;
      r_busy  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_SETTLE) ||
                 (w_state_nxt == S_CAPTURE);
    end
  end

  // Sweep sequencer; r_mask holds the channels still to be sampled in this sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_set_nxt   = r_set;
    w_mask_nxt  = r_mask;
    w_chan_nxt  = r_chan;
    w_rem       = r_mask & ~(3'b001 << r_chan);
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_cnt_nxt   = w_reload;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - PERIOD_W'(1);
        end else if (chan_mask != 3'b000) begin
          w_mask_nxt  = chan_mask;
          w_chan_nxt  = f_lowest(chan_mask);
          w_state_nxt = S_REQ;
        end else begin
          w_cnt_nxt = w_reload;
        end
      end
      S_REQ: begin
        w_set_nxt   = SET_W'(SETTLE_CYCLES - 1);
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_set == '0) w_state_nxt = S_CAPTURE;
        else             w_set_nxt   = r_set - SET_W'(1);
      end
      S_CAPTURE: begin
        w_push     = 1'b1;
        w_mask_nxt = w_rem;
        if (w_rem != 3'b000) begin
          w_chan_nxt  = f_lowest(w_rem);
          w_state_nxt = S_REQ;
        end else begin
          w_cnt_nxt   = w_reload;
          w_state_nxt = enable ? S_WAIT : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_toggle <= 3'b000;
    else if (r_state == S_REQ)  r_toggle <= r_toggle ^ (3'b001 << r_chan);
  end

  // Real-to-fixed: scale, truncate toward zero, saturate; NaN maps to zero.
  always_comb begin
    case (r_chan)
      2'd1:    w_sel = current_in;
      2'd2:    w_sel = power_in;
      default: w_sel = voltage_in;
    endcase
    w_scaled = w_sel * SCALE;
    w_trunc  = 0.0;
    w_conv   = '0;
    if (w_sel != w_sel) begin
      w_conv = '0;
    end else if (w_scaled >= LIMIT) begin
      w_conv = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_scaled <= -LIMIT) begin
      w_conv = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_trunc = (w_scaled < 0.0) ? $ceil(w_scaled) : $floor(w_scaled);
      w_conv  = DATA_W'(longint'(w_trunc));
    end
  end

  assign w_pop     = (r_count != '0) && m_ready;
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_chan[i] <= '0;
      end
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem_data[r_wr] <= w_conv;
        r_mem_chan[r_wr] <= r_chan;
        r_wr             <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A new drop outranks a simultaneous clear.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

`ifdef PROBE_TIMESTAMP_EN
  logic [31:0] r_ts, r_ts_req;
  logic [31:0] r_mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts     <= '0;
      r_ts_req <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem_ts[i] <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (r_state == S_REQ) r_ts_req <= r_ts;
      if (w_do_push) r_mem_ts[r_wr] <= r_ts_req;
    end
  end

  assign m_timestamp = r_mem_ts[r_rd];
`endif

  assign probe_voltage_toggle = r_toggle[0];
  assign probe_current_toggle = r_toggle[1];
  assign probe_power_toggle   = r_toggle[2];
  assign m_valid              = (r_count != '0);
  assign m_data               = r_mem_data[r_rd];
  assign m_chan               = r_mem_chan[r_rd];
  assign overflow             = r_overflow;
  assign busy                 = r_busy;

endmodule

// File: tb/tb_analog_probe_scheduler.sv
// Directed bench for analog_probe_scheduler: conversion table plus sweep, overflow, reset and enable sequences.
module tb_analog_probe_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period;
  logic [2:0]  chan_mask;
  logic        clr_overflow;
  logic        tog_v, tog_i, tog_p;
  real         vin, iin, pin;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_chan;
  logic        overflow, busy;
`ifdef PROBE_TIMESTAMP_EN
  logic [31:0] m_timestamp;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  analog_probe_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .period               (period),
    .chan_mask            (chan_mask),
    .clr_overflow         (clr_overflow),
    .probe_voltage_toggle (tog_v),
    .probe_current_toggle (tog_i),
    .probe_power_toggle   (tog_p),
    .voltage_in           (vin),
    .current_in           (iin),
    .power_in             (pin),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_data               (m_data),
    .m_chan               (m_chan),
`ifdef PROBE_TIMESTAMP_EN
    .m_timestamp          (m_timestamp),
`endif
    .overflow             (overflow),
    .busy                 (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    real         v;
    logic [31:0] exp_data;
  } conv_vec_t;

  conv_vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0; period = 16'd10; chan_mask = 3'b001; clr_overflow = 1'b0;
    m_ready = 1'b0; vin = 0.0; iin = 0.0; pin = 0.0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    for (n = 0; n < 60 && !m_valid; n++) tick();
    if (!m_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_vflip(input string name);
    logic prev;
    int n;
    prev = tog_v;
    for (n = 0; n < 60 && tog_v == prev; n++) tick();
    if (tog_v == prev) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Run 9 single-channel sweeps with m_ready low; sweep k samples value k. Returns in the 9th sweep's first settle cycle.
  task automatic fill_nine();
    period = 16'd1; chan_mask = 3'b001; m_ready = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_vflip("fill_flip");
      vin = real'(k);
    end
  endtask

  task automatic drain_expect(input string name, input int first);
    int got;
    got = 0;
    m_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (m_valid) begin
        chk({name, "_data"}, 64'(m_data), 64'(32'(first + got) << 16));
        chk({name, "_chan"}, 64'(m_chan), 64'd0);
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    chk({name, "_count"}, 64'(got), 64'd8);
  endtask

  initial begin
    int          last_cyc;
    int          busy_cnt;
    int          flips;
    int          late_flips;
    logic [2:0]  prev_tog;
    logic [1:0]  q_chan [$];
    logic [31:0] q_data [$];
    real         nan_v;

    nan_v = $bitstoreal(64'h7FF8000000000000);
    vecs[0]  = '{1.5,                 32'h00018000};
    vecs[1]  = '{0.5,                 32'h00008000};
    vecs[2]  = '{-1.25,               32'hFFFEC000};
    vecs[3]  = '{2.0,                 32'h00020000};
    vecs[4]  = '{40000.0,             32'h7FFFFFFF};
    vecs[5]  = '{-40000.0,            32'h80000000};
    vecs[6]  = '{32767.0,             32'h7FFF0000};
    vecs[7]  = '{-32768.0,            32'h80000000};
    vecs[8]  = '{-2.288818359375e-05, 32'hFFFFFFFF};
    vecs[9]  = '{7.62939453125e-06,   32'h00000000};
    vecs[10] = '{nan_v,               32'h00000000};

    // Reset state
    do_reset();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_chan", 64'(m_chan), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_toggles", 64'({tog_p, tog_i, tog_v}), 64'd0);

    // Conversion table on voltage channel, period 10 -> one sweep every 14 cycles
    period = 16'd10; chan_mask = 3'b001; enable = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 11; i++) begin
      vin = vecs[i].v;
      wait_valid("conv_wait");
      chk($sformatf("conv%0d_data", i), 64'(m_data), 64'(vecs[i].exp_data));
      chk($sformatf("conv%0d_chan", i), 64'(m_chan), 64'd0);
      chk($sformatf("conv%0d_toggle", i), 64'(tog_v), 64'((i + 1) % 2));
      if (i > 0) chk($sformatf("conv%0d_spacing", i), 64'(cyc - last_cyc), 64'd14);
      last_cyc = cyc;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    enable = 1'b0;

    // Full sweep: order, negative value, busy length
    do_reset();
    vin = 0.5; iin = -1.25; pin = 2.0;
    chan_mask = 3'b111; m_ready = 1'b1; period = 16'd10; enable = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (busy) busy_cnt++;
      if (m_valid) begin
        q_chan.push_back(m_chan);
        q_data.push_back(m_data);
      end
    end
    enable = 1'b0;
    chk("sweep_busy_cycles", 64'(busy_cnt), 64'd12);
    chk("sweep_entries", 64'(q_chan.size()), 64'd3);
    if (q_chan.size() == 3) begin
      chk("sweep0_chan", 64'(q_chan[0]), 64'd0);
      chk("sweep0_data", 64'(q_data[0]), 64'h00008000);
      chk("sweep1_chan", 64'(q_chan[1]), 64'd1);
      chk("sweep1_data", 64'(q_data[1]), 64'hFFFEC000);
      chk("sweep2_chan", 64'(q_chan[2]), 64'd2);
      chk("sweep2_data", 64'(q_data[2]), 64'h00020000);
    end

    // Enable and mask changed mid-sweep: sweep completes, then stops
    do_reset();
    vin = 1.0; iin = 2.0; pin = 3.0;
    chan_mask = 3'b111; m_ready = 1'b1; period = 16'd10; enable = 1'b1;
    for (int n = 0; n < 40 && !busy; n++) tick();
    chk("mid_busy_seen", 64'(busy), 64'd1);
    enable = 1'b0; chan_mask = 3'b001;
    prev_tog = {tog_p, tog_i, tog_v};
    flips = 0; late_flips = 0;
    q_chan.delete();
    for (int n = 0; n < 60; n++) begin
      tick();
      if ({tog_p, tog_i, tog_v} != prev_tog) begin
        flips++;
        if (!busy) late_flips++;
      end
      prev_tog = {tog_p, tog_i, tog_v};
      if (m_valid) q_chan.push_back(m_chan);
    end
    chk("mid_entries", 64'(q_chan.size()), 64'd3);
    if (q_chan.size() == 3) chk("mid_last_chan", 64'(q_chan[2]), 64'd2);
    chk("mid_flips", 64'(flips), 64'd3);
    chk("mid_late_flips", 64'(late_flips), 64'd0);
    chk("mid_busy_end", 64'(busy), 64'd0);

    // Reset asserted mid-settle
    do_reset();
    vin = 1.0; period = 16'd10; chan_mask = 3'b001; enable = 1'b1;
    wait_vflip("rst_mid_flip");
    rst = 1'b1;
    #1;
    chk("rst_mid_toggle", 64'(tog_v), 64'd0);
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("rst_mid_no_push", 64'(m_valid), 64'd0);

    // Overflow: 9th sample dropped, clear, drain first 8
    do_reset();
    fill_nine();
    chk("ovf_before", 64'(overflow), 64'd0);
    chk("ovf_full_valid", 64'(m_valid), 64'd1);
    tick(); tick(); tick();
    enable = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    drain_expect("ovf_drain", 1);

    // Full FIFO with pop coinciding with push: no drop
    do_reset();
    fill_nine();
    tick(); tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; enable = 1'b0;
    chk("pushpop_no_ovf", 64'(overflow), 64'd0);
    drain_expect("pushpop_drain", 2);

`ifdef PROBE_TIMESTAMP_EN
    begin
      logic [31:0] ts0;
      do_reset();
      vin = 1.0; period = 16'd10; chan_mask = 3'b001; enable = 1'b1;
      wait_valid("ts_wait0");
      ts0 = m_timestamp;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      wait_valid("ts_wait1");
      chk("ts_delta", 64'(m_timestamp - ts0), 64'd14);
      enable = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/analog_probe_scheduler.md
Name: analog_probe_scheduler

Overview:
- Digital front end for the analog probe block.
- Periodically issues voltage/current/power probe requests by toggling that block's per-quantity toggle inputs.
- Waits a fixed settle time, captures the returned real value and converts it to signed fixed-point.
- Pushes each sample, with a channel tag, into an output FIFO read by the testbench or a monitor over valid/ready.

Parameters:
- PERIOD_W, 16, width of the sample-period input.
- SETTLE_CYCLES, 2, clock cycles between a toggle edge and value capture (min 1).
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2).
- DATA_W, 32, width of the fixed-point sample.
- FRAC_BITS, 16, fractional bits of the fixed-point sample.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  run periodic sweeps.
- period  in  PERIOD_W  idle cycles between sweeps; 0 is treated as 1.
- chan_mask  in  3  bit0 voltage, bit1 current, bit2 power.
- clr_overflow  in  1  clears the overflow flag.
- probe_voltage_toggle  out  1  to probe block.
- probe_current_toggle  out  1  to probe block.
- probe_power_toggle  out  1  to probe block.
- voltage_in  in  real  from probe block.
- current_in  in  real  from probe block.
- power_in  in  real  from probe block.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- m_data  out  DATA_W  signed fixed-point sample.
- m_chan  out  2  channel tag: 0=V, 1=I, 2=P.
- overflow  out  1  sticky; a sample was dropped on a full FIFO.
- busy  out  1  sweep in progress.

Behaviour:
- Reset: all toggles 0, FIFO empty, m_valid 0, m_data 0, m_chan 0, overflow 0, busy 0, FSM in IDLE, period counter 0.
- FSM states:
  - IDLE: when enable=1, load counter with max(period,1)-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, if chan_mask!=0, latch the mask, go to REQ on the lowest set channel, busy=1. If chan_mask==0, reload the counter and stay in WAIT. If enable=0, return to IDLE.
  - REQ: one cycle; invert the selected channel's toggle output.
  - SETTLE: SETTLE_CYCLES cycles.
  - CAPTURE: one cycle.
    - Sample the selected real input.
    - Convert it and push {chan, data}.
    - Go to REQ for the next set bit of the latched mask (order V, I, P).
    - If none remain: busy=0, reload the counter, go to WAIT if enable=1, else IDLE.
- Per-channel cost is 2+SETTLE_CYCLES cycles. Sweep starts are separated by max(period,1) + nchan*(2+SETTLE_CYCLES) cycles.
- Mid-sweep rules:
  - chan_mask changes during a sweep are ignored until the next sweep.
  - Deasserting enable mid-sweep completes the current sweep, then goes to IDLE.
- Conversion:
  - Scale by 2^FRAC_BITS and truncate toward zero.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - NaN converts to 0.
- FIFO:
  - m_data/m_chan always show the head entry; pop on m_valid&&m_ready.
  - Push to a full FIFO with no simultaneous pop: sample dropped, overflow set.
  - Push and pop in the same cycle on a full FIFO: both succeed, no overflow.
  - Push to an empty FIFO: m_valid rises the cycle after CAPTURE.
- overflow: clr_overflow clears it; if clr_overflow and a new drop coincide, set wins.
- Reset asserted mid-sweep: immediate return to reset state, FIFO flushed, toggles forced to 0.

Optional Feature:
- Macro PROBE_TIMESTAMP_EN.
- When defined:
  - Adds port m_timestamp (out, 32), a free-running cycle counter (reset 0, wraps at 2^32).
  - The counter value is latched in REQ and stored with each FIFO entry.
- When undefined: the port and counter are absent, and FIFO entry width is DATA_W+2.

Test Plan:
- Single channel, basic conversion:
  - Stimulus: enable=1, period=10, chan_mask=3'b001, voltage_in=1.5.
  - Response: probe_voltage_toggle flips once per 14 cycles; m_data=32'h00018000, m_chan=0.
- Full sweep, order and negative value:
  - Stimulus: chan_mask=3'b111, V=0.5, I=-1.25, P=2.0, m_ready=1.
  - Response: entries in order (0, 32'h00008000), (1, 32'hFFFEC000), (2, 32'h00020000); busy high for 12 cycles.
- Saturation:
  - Stimulus: voltage_in=40000.0, then -40000.0.
  - Response: m_data=32'h7FFFFFFF, then 32'h80000000.
- Overflow:
  - Stimulus: m_ready=0, chan_mask=3'b001, 9 sweeps with FIFO_DEPTH=8.
  - Response: 8 entries retained, overflow=1 after the 9th CAPTURE; clr_overflow clears it; draining yields the first 8 samples in order.
- Reset and enable interactions:
  - Reset mid-SETTLE: toggles 0, m_valid 0, no push occurs.
  - enable dropped mid-sweep: remaining channels still captured, then busy=0 and no further toggles.
- Timestamp (PROBE_TIMESTAMP_EN defined):
  - Stimulus: two consecutive single-channel sweeps, period=10.
  - Response: m_timestamp delta between the two entries = 14.
